acq_dopp_sched: RTL and testbench

Sequences the PRN-phase acquisition engine across a grid of Doppler bins. For each bin it programs a carrier-FCW offset, holds the engine in reset while that offset settles, waits for the engine's end-of-search result, and keeps the best peak, phase and bin. After the full sweep it compares the best peak against a threshold. On success it leaves the winning offset applied and pulses a tracking-start strobe. It sits between the receiver control logic and the acquisition/correlator datapath.

---
 rtl/acq_dopp_sched.sv | 206 ++++++++++++++++++++
 tb/tb_acq_dopp_sched.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/acq_dopp_sched.sv
// Doppler-bin sweep controller for the PRN acquisition engine: steps the carrier
// offset across the bin grid, keeps the strongest peak and parks the winner for tracking.
//
// state | meaning
// IDLE  | waiting for rx_start; engine in reset unless a found result is parked
// CFG   | bin offset applied, engine held in reset while the carrier settles
// RUN   | engine searching, watchdog counting
// EVAL  | compare captured peak with best, step to next bin
// FIN   | threshold decision, done / tracking-start strobes
module acq_dopp_sched #(
    parameter int          ACC_WIDTH     = 32,
    parameter int          CORR_WIDTH    = 32,
    parameter int          PRN_PHS_WIDTH = 12,
    parameter int          BIN_WIDTH     = 5,
    parameter int          NUM_BINS      = 21,
    parameter logic [31:0] DOPP_STEP     = 32'd214748,
    parameter int          SETTLE_CYCLES = 16,
    parameter int          TMO_WIDTH     = 20
) (
    input  logic                     rx_clk,
    input  logic                     rx_rst_n,
    input  logic                     rx_start,
    input  logic                     rx_abort,
    input  logic [CORR_WIDTH-1:0]    rx_thresh,
    input  logic                     rx_acq_done,
    input  logic [CORR_WIDTH-1:0]    rx_corr_peak,
    input  logic [PRN_PHS_WIDTH-1:0] rx_acq_phs,
    output logic                     tx_eng_rst,
    output logic [ACC_WIDTH-1:0]     tx_car_fcw_ofs,
    output logic [BIN_WIDTH-1:0]     tx_bin,
    output logic                     tx_busy,
    output logic                     tx_done,
    output logic                     tx_found,
    output logic                     tx_timeout,
    output logic                     tx_trk_start,
    output logic [CORR_WIDTH-1:0]    tx_best_peak,
    output logic [PRN_PHS_WIDTH-1:0] tx_best_phs,
    output logic [BIN_WIDTH-1:0]     tx_best_bin
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CFG  = 3'd1,
        ST_RUN  = 3'd2,
        ST_EVAL = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    localparam int                   HALF        = (NUM_BINS - 1) / 2;
    localparam int                   SET_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [ACC_WIDTH-1:0] STEP        = ACC_WIDTH'(DOPP_STEP);
    localparam logic [ACC_WIDTH-1:0] OFS_START   = ACC_WIDTH'(0) - (ACC_WIDTH'(HALF) * STEP);
    localparam logic [BIN_WIDTH-1:0] LAST_BIN    = BIN_WIDTH'(NUM_BINS - 1);
    localparam logic [SET_W-1:0]     SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
    // Watchdog expires on the cycle its count would reach all-ones.
    localparam logic [TMO_WIDTH-1:0] TMO_LAST    = {{(TMO_WIDTH-1){1'b1}}, 1'b0};

    state_t                   state_q, state_d;
    logic [CORR_WIDTH-1:0]    thresh_q, cap_peak_q, best_peak_q;
    logic [PRN_PHS_WIDTH-1:0] cap_phs_q, best_phs_q;
    logic [BIN_WIDTH-1:0]     bin_q, best_bin_q;
    logic [ACC_WIDTH-1:0]     ofs_q;
    logic [SET_W-1:0]         settle_q;
    logic [TMO_WIDTH-1:0]     wdog_q;
    logic                     found_q, hold_q, timeout_q;

    logic settle_tc, wdog_tc, last_bin, found_now;

    assign settle_tc = (settle_q == '0);
    assign wdog_tc   = (wdog_q == TMO_LAST);
    assign last_bin  = (bin_q == LAST_BIN);
    assign found_now = (best_peak_q >= thresh_q) && (best_peak_q != '0);

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rx_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (rx_start) state_d = ST_CFG;
                ST_CFG:  if (settle_tc) state_d = ST_RUN;
                ST_RUN:  if (rx_acq_done || wdog_tc) state_d = ST_EVAL;
                ST_EVAL: state_d = last_bin ? ST_FIN : ST_CFG;
                ST_FIN:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        tx_eng_rst   = 1'b1;
        tx_busy      = 1'b1;
        tx_done      = 1'b0;
        tx_trk_start = 1'b0;
        tx_found     = found_q;
        case (state_q)
            ST_IDLE: begin
                tx_eng_rst = ~hold_q;
                tx_busy    = 1'b0;
            end
            ST_CFG:  tx_eng_rst = 1'b1;
            ST_RUN:  tx_eng_rst = 1'b0;
            ST_EVAL: tx_eng_rst = 1'b0;
            ST_FIN: begin
                tx_eng_rst   = ~found_now;
                tx_done      = 1'b1;
                tx_trk_start = found_now;
                tx_found     = found_now;
            end
            default: tx_busy = 1'b0;
        endcase
    end

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            thresh_q    <= '0;
            cap_peak_q  <= '0;
            cap_phs_q   <= '0;
            best_peak_q <= '0;
            best_phs_q  <= '0;
            best_bin_q  <= '0;
            bin_q       <= '0;
            ofs_q       <= '0;
            settle_q    <= '0;
            wdog_q      <= '0;
            found_q     <= 1'b0;
            hold_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else if (rx_abort) begin
            // Best registers survive an abort so the partial sweep stays observable.
            found_q <= 1'b0;
            hold_q  <= 1'b0;
            if (state_q == ST_IDLE) ofs_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_start) begin
                        thresh_q    <= rx_thresh;
                        bin_q       <= '0;
                        ofs_q       <= OFS_START;
                        best_peak_q <= '0;
                        best_phs_q  <= '0;
                        best_bin_q  <= '0;
                        timeout_q   <= 1'b0;
                        found_q     <= 1'b0;
                        hold_q      <= 1'b0;
                        settle_q    <= SETTLE_LOAD;
                    end
                end
                ST_CFG: begin
                    wdog_q <= '0;
                    if (!settle_tc) settle_q <= settle_q - 1'b1;
                end
                ST_RUN: begin
                    if (rx_acq_done) begin
                        cap_peak_q <= rx_corr_peak;
                        cap_phs_q  <= rx_acq_phs;
                    end else if (wdog_tc) begin
                        cap_peak_q <= '0;
                        timeout_q  <= 1'b1;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                ST_EVAL: begin
                    // Strict compare: on a tie the earlier (lower) bin wins.
                    if (cap_peak_q > best_peak_q) begin
                        best_peak_q <= cap_peak_q;
                        best_phs_q  <= cap_phs_q;
                        best_bin_q  <= bin_q;
                    end
                    if (!last_bin) begin
                        bin_q    <= bin_q + 1'b1;
                        ofs_q    <= ofs_q + STEP;
                        settle_q <= SETTLE_LOAD;
                    end
                end
                ST_FIN: begin
                    found_q <= found_now;
                    hold_q  <= found_now;
                    if (found_now) begin
                        ofs_q <= OFS_START + (ACC_WIDTH'(best_bin_q) * STEP);
                        bin_q <= best_bin_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tx_car_fcw_ofs = ofs_q;
    assign tx_bin         = bin_q;
    assign tx_timeout     = timeout_q;
    assign tx_best_peak   = best_peak_q;
    assign tx_best_phs    = best_phs_q;
    assign tx_best_bin    = best_bin_q;

endmodule

// File: tb/tb_acq_dopp_sched.sv
// Bench for acq_dopp_sched: emulates the acquisition engine and checks each sweep
// against a bin-by-bin best-peak model of the scheduler.
module tb_acq_dopp_sched;

    localparam int NB      = 5;
    localparam int STEP    = 100;
    localparam int SETTLE  = 4;
    localparam int TMOW    = 6;
    localparam int CW      = 32;
    localparam int PW      = 12;
    localparam int BW      = 5;
    localparam int AW      = 32;
    localparam int HALF    = (NB - 1) / 2;
    localparam int TMO_RUN = (1 << TMOW) - 1;

    logic          rx_clk = 1'b0;
    logic          rx_rst_n = 1'b0;
    logic          rx_start = 1'b0;
    logic          rx_abort = 1'b0;
    logic [CW-1:0] rx_thresh = '0;
    logic          rx_acq_done = 1'b0;
    logic [CW-1:0] rx_corr_peak = '0;
    logic [PW-1:0] rx_acq_phs = '0;
    logic          tx_eng_rst, tx_busy, tx_done, tx_found, tx_timeout, tx_trk_start;
    logic [AW-1:0] tx_car_fcw_ofs;
    logic [BW-1:0] tx_bin, tx_best_bin;
    logic [CW-1:0] tx_best_peak;
    logic [PW-1:0] tx_best_phs;

    acq_dopp_sched #(
        .ACC_WIDTH(AW), .CORR_WIDTH(CW), .PRN_PHS_WIDTH(PW), .BIN_WIDTH(BW),
        .NUM_BINS(NB), .DOPP_STEP(32'(STEP)), .SETTLE_CYCLES(SETTLE), .TMO_WIDTH(TMOW)
    ) dut (
        .rx_clk(rx_clk), .rx_rst_n(rx_rst_n), .rx_start(rx_start), .rx_abort(rx_abort),
        .rx_thresh(rx_thresh), .rx_acq_done(rx_acq_done), .rx_corr_peak(rx_corr_peak),
        .rx_acq_phs(rx_acq_phs), .tx_eng_rst(tx_eng_rst), .tx_car_fcw_ofs(tx_car_fcw_ofs),
        .tx_bin(tx_bin), .tx_busy(tx_busy), .tx_done(tx_done), .tx_found(tx_found),
        .tx_timeout(tx_timeout), .tx_trk_start(tx_trk_start), .tx_best_peak(tx_best_peak),
        .tx_best_phs(tx_best_phs), .tx_best_bin(tx_best_bin)
    );

    always #5 rx_clk = ~rx_clk;

    int n_cmp = 0;
    int n_bad = 0;

    int unsigned pk[NB];
    int unsigned ph[NB];
    int          dly[NB];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] exp_ofs(input int b);
        return AW'((b - HALF) * STEP);
    endfunction

    // One sweep. tmo_bin: bin that never gets done (-1 none). abort_bin: abort at its CFG (-1 none).
    task automatic sweep(input logic [CW-1:0] thr, input int tmo_bin, input int abort_bin, input bit noise);
        int unsigned best, best_p, p;
        int          best_b, cyc, n, lat_exp, lim;
        bit          found_e, tmo_e;
        best = 0; best_p = 0; best_b = 0; lat_exp = 1;
        lim = (abort_bin >= 0) ? abort_bin : NB;
        for (int b = 0; b < lim; b++) begin
            p = (b == tmo_bin) ? 0 : pk[b];
            if (p > best) begin
                best = p; best_p = ph[b]; best_b = b;
            end
            lat_exp += SETTLE + ((b == tmo_bin) ? TMO_RUN : dly[b]) + 1;
        end
        found_e = (best >= thr) && (best != 0);
        tmo_e   = (tmo_bin >= 0) && (tmo_bin < lim);

        @(negedge rx_clk);
        rx_start = 1'b1; rx_thresh = thr;
        @(negedge rx_clk);
        rx_start = 1'b0; rx_thresh = $urandom;
        cyc = 1;
        chk("busy_after_start", 64'(tx_busy), 64'(1));
        chk("found_cleared", 64'(tx_found), 64'(0));
        chk("timeout_cleared", 64'(tx_timeout), 64'(0));

        for (int b = 0; b < NB; b++) begin
            chk("cfg_bin", 64'(tx_bin), 64'(b));
            if (b == abort_bin) begin
                rx_abort = 1'b1; rx_start = 1'b1;
                @(negedge rx_clk);
                rx_abort = 1'b0; rx_start = 1'b0;
                chk("abort_busy", 64'(tx_busy), 64'(0));
                chk("abort_eng_rst", 64'(tx_eng_rst), 64'(1));
                chk("abort_no_done", 64'(tx_done), 64'(0));
                chk("abort_found", 64'(tx_found), 64'(0));
                chk("abort_best_peak", 64'(tx_best_peak), 64'(best));
                chk("abort_best_bin", 64'(tx_best_bin), 64'(best_b));
                @(negedge rx_clk);
                chk("abort_start_dropped", 64'(tx_busy), 64'(0));
                return;
            end
            n = 0;
            while (tx_eng_rst === 1'b1 && n < SETTLE + 10) begin
                chk("cfg_ofs", 64'(tx_car_fcw_ofs), 64'(exp_ofs(b)));
                rx_acq_done  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                rx_corr_peak = '1;
                n++; cyc++;
                @(negedge rx_clk);
            end
            rx_acq_done = 1'b0;
            chk("settle_len", 64'(n), 64'(SETTLE));
            if (b == tmo_bin) begin
                n = 1;
                while (tx_timeout !== 1'b1 && n < 200) begin
                    rx_start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                    n++; cyc++;
                    @(negedge rx_clk);
                end
                rx_start = 1'b0;
                chk("tmo_run_len", 64'(n - 1), 64'(TMO_RUN));
            end else begin
                repeat (dly[b] - 1) begin
                    rx_start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                    cyc++;
                    @(negedge rx_clk);
                end
                rx_start = 1'b0;
                rx_acq_done = 1'b1; rx_corr_peak = pk[b]; rx_acq_phs = PW'(ph[b]);
                cyc++;
                @(negedge rx_clk);
                rx_acq_done = 1'b0;
                chk("eval_eng_rst", 64'(tx_eng_rst), 64'(0));
            end
            cyc++;
            @(negedge rx_clk);
        end

        chk("latency", 64'(cyc), 64'(lat_exp));
        chk("fin_done", 64'(tx_done), 64'(1));
        chk("fin_trk_start", 64'(tx_trk_start), 64'(found_e));
        chk("fin_found", 64'(tx_found), 64'(found_e));
        chk("fin_best_peak", 64'(tx_best_peak), 64'(best));
        chk("fin_best_phs", 64'(tx_best_phs), 64'(best_p));
        chk("fin_best_bin", 64'(tx_best_bin), 64'(best_b));
        chk("fin_timeout", 64'(tx_timeout), 64'(tmo_e));
        @(negedge rx_clk);
        chk("post_done", 64'(tx_done), 64'(0));
        chk("post_trk", 64'(tx_trk_start), 64'(0));
        chk("post_busy", 64'(tx_busy), 64'(0));
        chk("post_found", 64'(tx_found), 64'(found_e));
        chk("post_eng_rst", 64'(tx_eng_rst), 64'(!found_e));
        if (found_e) begin
            chk("held_ofs", 64'(tx_car_fcw_ofs), 64'(exp_ofs(best_b)));
            chk("held_bin", 64'(tx_bin), 64'(best_b));
            repeat (3) @(negedge rx_clk);
            chk("hold_eng_rst", 64'(tx_eng_rst), 64'(0));
            chk("hold_ofs", 64'(tx_car_fcw_ofs), 64'(exp_ofs(best_b)));
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_eng_rst"}, 64'(tx_eng_rst), 64'(1));
        chk({tag, "_busy"}, 64'(tx_busy), 64'(0));
        chk({tag, "_found"}, 64'(tx_found), 64'(0));
        chk({tag, "_done"}, 64'(tx_done), 64'(0));
        chk({tag, "_ofs"}, 64'(tx_car_fcw_ofs), 64'(0));
        chk({tag, "_bin"}, 64'(tx_bin), 64'(0));
        chk({tag, "_best_peak"}, 64'(tx_best_peak), 64'(0));
        chk({tag, "_best_bin"}, 64'(tx_best_bin), 64'(0));
        chk({tag, "_timeout"}, 64'(tx_timeout), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(negedge rx_clk);
        chk_reset_vals("reset");
        rx_rst_n = 1'b1;
        @(negedge rx_clk);

        // Engine done in IDLE must be ignored.
        rx_acq_done = 1'b1; rx_corr_peak = 32'd999;
        @(negedge rx_clk);
        rx_acq_done = 1'b0;
        @(negedge rx_clk);
        chk("idle_done_busy", 64'(tx_busy), 64'(0));
        chk("idle_done_peak", 64'(tx_best_peak), 64'(0));
        chk("idle_done_eng_rst", 64'(tx_eng_rst), 64'(1));

        pk = '{10, 80, 30, 80, 5};
        for (int i = 0; i < NB; i++) begin
            ph[i]  = $urandom_range(0, 4095);
            dly[i] = 10;
        end
        sweep(32'd50, -1, -1, 1'b0);

        // Abort in IDLE releases the parked found result.
        @(negedge rx_clk);
        rx_abort = 1'b1;
        @(negedge rx_clk);
        rx_abort = 1'b0;
        chk("idle_abort_eng_rst", 64'(tx_eng_rst), 64'(1));
        chk("idle_abort_ofs", 64'(tx_car_fcw_ofs), 64'(0));

        sweep(32'd100, -1, -1, 1'b0);
        sweep(32'd50, 2, -1, 1'b0);
        sweep(32'd50, -1, 3, 1'b0);

        for (int s = 0; s < 10; s++) begin
            for (int i = 0; i < NB; i++) begin
                pk[i]  = $urandom_range(0, 15) * 10;
                ph[i]  = $urandom_range(0, 4095);
                dly[i] = $urandom_range(1, 20);
            end
            sweep(CW'($urandom_range(0, 160)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NB - 1)) : -1,
                  ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, NB - 1)) : -1,
                  1'b1);
        end

        // Park a found result, then reset asynchronously mid-cycle.
        pk = '{10, 80, 30, 80, 5};
        sweep(32'd50, -1, -1, 1'b0);
        #2 rx_rst_n = 1'b0;
        #1 chk_reset_vals("async_idle");
        @(negedge rx_clk);
        rx_rst_n = 1'b1;

        // Reset arriving while the engine is running.
        @(negedge rx_clk);
        rx_start = 1'b1; rx_thresh = 32'd50;
        @(negedge rx_clk);
        rx_start = 1'b0;
        n = 0;
        while (tx_eng_rst === 1'b1 && n < 20) begin
            n++;
            @(negedge rx_clk);
        end
        chk("run_reached_busy", 64'(tx_busy), 64'(1));
        repeat (3) @(negedge rx_clk);
        #2 rx_rst_n = 1'b0;
        #1 chk_reset_vals("async_run");
        @(negedge rx_clk);
        rx_rst_n = 1'b1;
        repeat (2) @(negedge rx_clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
